// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: active-high abcdefg glyphs
// (bit 6 = a, bit 0 = g) and an index-width helper.
package ssd_pkg;

    localparam logic [6:0] SEG_0   = 7'h7E;
    localparam logic [6:0] SEG_1   = 7'h30;
    localparam logic [6:0] SEG_2   = 7'h6D;
    localparam logic [6:0] SEG_3   = 7'h79;
    localparam logic [6:0] SEG_4   = 7'h33;
    localparam logic [6:0] SEG_5   = 7'h5B;
    localparam logic [6:0] SEG_6   = 7'h5F;
    localparam logic [6:0] SEG_7   = 7'h70;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h7B;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h1F;
    localparam logic [6:0] SEG_C   = 7'h4E;
    localparam logic [6:0] SEG_D   = 7'h3D;
    localparam logic [6:0] SEG_E   = 7'h4F;
    localparam logic [6:0] SEG_F   = 7'h47;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Never returns 0, so a single-digit build still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-high abcdefg segment pattern.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scanner with per-frame snapshot, anti-ghost blanking,
// leading-zero suppression, per-digit enable and decimal point.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_BITS = 18,
    parameter int BLANK_CYCLES  = 64,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic                    frame_start
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            CA_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [SCAN_DIV_BITS-1:0]      presc;
    logic [IDX_W-1:0]              idx;
    logic [NUM_DIGITS-1:0][3:0]    val_sh;
    logic [NUM_DIGITS-1:0]         dp_sh;
    logic [NUM_DIGITS-1:0]         en_sh;
    logic                          lz_sh;

    logic                          frame_tick;
    logic                          upper_nz;
    logic                          lit;
    logic [3:0]                    nib;
    logic [6:0]                    seg;
    logic [NUM_DIGITS-1:0]         an_nxt;
    logic [7:0]                    ca_nxt;

    assign frame_tick = (presc == '0) && (idx == '0);
    assign nib        = val_sh[idx];

    ssd_hex_decode u_dec (.nib(nib), .seg(seg));

    // Anything nonzero (nibble or dp) at or above the current digit keeps it lit.
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (j >= int'(idx) && (val_sh[j] != 4'h0 || dp_sh[j]))
                upper_nz = 1'b1;
    end

    always_comb begin
        lit    = (presc >= SCAN_DIV_BITS'(BLANK_CYCLES)) && en_sh[idx]
                 && !((idx != '0) && lz_sh && !upper_nz);
        an_nxt = '0;
        ca_nxt = 8'h00;
        if (lit) begin
            an_nxt = NUM_DIGITS'(1) << idx;
            ca_nxt = {seg, dp_sh[idx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            idx         <= '0;
            val_sh      <= '0;
            dp_sh       <= '0;
            en_sh       <= '0;
            lz_sh       <= 1'b0;
            frame_start <= 1'b0;
            anode       <= AN_OFF;
            cathode     <= CA_OFF;
        end else begin
            presc <= presc + 1'b1;
            if (presc == '1)
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            if (frame_tick) begin
                val_sh <= value;
                dp_sh  <= dp_in;
                en_sh  <= digit_en;
                lz_sh  <= lz_blank;
            end
            frame_start <= frame_tick;
            anode       <= an_nxt ^ AN_OFF;
            cathode     <= ca_nxt ^ CA_OFF;
        end
    end

endmodule
